// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence-detector controller.
// Contents: controller state enum, default width constants, legal-length check.
package seq_det_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned TO_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A pattern length is usable when it selects at least one and at most pat_w bits.
    function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
        return (len >= 1) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Serial shift window with fill tracking and length-masked pattern compare.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           clear window and fill (run start)
//   shift         accept serial bit x this cycle
//   x             serial bit
//   pattern       right-aligned pattern, bit [len-1] is the oldest bit
//   len           active pattern length
//   overlap       1 = keep fill after a hit, 0 = restart fill
//   hit           combinational: the bit accepted this cycle completes a match
module seq_window_cmp
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0] window_q;
    logic [PAT_W-1:0] window_d;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_d;

    // Low len bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    // Hit is judged on the window and fill as they will be after this shift.
    always_comb begin
        window_d = {window_q[PAT_W-2:0], x};
        fill_d   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        hit      = shift && (fill_d >= len) && (((window_d ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (shift) begin
            window_q <= window_d;
            fill_q   <= (hit && !overlap) ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller: accepts a pattern config
// over valid/ready, runs detection, counts matches, ends on target or abort.
// Optional macro SEQ_DET_CTRL_TIMEOUT_EN adds TO_W, to_limit and timeout.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           config handshake (ready only in IDLE)
//   cfg_pattern/len/overlap/target  config payload
//   cfg_err                       one-cycle pulse on rejected config
//   start, abort                  run control
//   x_valid, x                    serial input
//   match                         one-cycle pulse per detection
//   match_cnt                     saturating match count for the current run
//   busy, done                    RUN / DONE status levels
//   to_limit, timeout             (timeout build only) idle-cycle limit and flag
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TO_W  = TO_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             cfg_err,
    input  logic             start,
    input  logic             abort,
    input  logic             x_valid,
    input  logic             x,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    ,
    input  logic [TO_W-1:0]  to_limit,
    output logic             timeout
`endif
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             match_d;
    logic             err_d;
    logic             clr;
    logic             shift;
    logic             hit;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TO_W-1:0]  to_lim_q, to_lim_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_d;
`endif

    assign shift   = (state_q == ST_RUN) && x_valid;
    assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);

    seq_window_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_win (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .shift   (shift),
        .x       (x),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    // Next-state and next-output logic; abort outranks a same-cycle hit.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        cnt_d   = match_cnt;
        match_d = 1'b0;
        err_d   = 1'b0;
        clr     = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        to_lim_d  = to_lim_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (len_legal(32'(cfg_len), PAT_W)) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        tgt_d   = cfg_target;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                        to_lim_d = to_limit;
`endif
                        state_d = ST_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READY, ST_DONE: begin
                if (abort) begin
                    pat_d   = '0;
                    len_d   = '0;
                    ovl_d   = 1'b0;
                    tgt_d   = '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    to_lim_d  = '0;
                    timeout_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end else if (start) begin
                    cnt_d   = '0;
                    clr     = 1'b1;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                to_cnt_d = hit ? '0 : to_cnt_q + TO_W'(1);
`endif
                if (abort) begin
                    state_d = ST_DONE;
                end else if (hit) begin
                    match_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                        state_d = ST_DONE;
                    end
                end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                else if ((to_lim_q != '0) && (to_cnt_q == to_lim_q)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, stored config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            to_lim_q  <= '0;
            to_cnt_q  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            match_cnt <= cnt_d;
            match     <= match_d;
            cfg_err   <= err_d;
            cfg_ready <= (state_d == ST_IDLE);
            busy      <= (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            to_lim_q  <= to_lim_d;
            to_cnt_q  <= to_cnt_d;
            timeout   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a bit-history reference model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 8;

    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             x_valid;
    logic             x;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [15:0]      to_limit;
    logic             timeout;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: run phase, stored config, and the bits seen since the
    // run began or since the last non-overlapping match.
    int m_state;
    int m_pat;
    int m_len;
    int m_tgt;
    int m_cnt;
    bit m_ovl;
    bit m_match;
    bit m_err;
    int hist[$];

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        ,
        .to_limit    (to_limit),
        .timeout     (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value of the newest n bits of history, oldest bit most significant.
    function automatic int tail(input int n);
        int v = 0;
        for (int i = hist.size() - n; i < hist.size(); i++) v = (v << 1) | hist[i];
        return v;
    endfunction

    task automatic model_step();
        m_match = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_state = M_IDLE;
            m_pat = 0; m_len = 0; m_tgt = 0; m_cnt = 0; m_ovl = 1'b0;
            hist.delete();
        end else begin
            case (m_state)
                M_IDLE: if (cfg_valid) begin
                    if (int'(cfg_len) >= 1 && int'(cfg_len) <= int'(PAT_W)) begin
                        m_pat = int'(cfg_pattern);
                        m_len = int'(cfg_len);
                        m_ovl = cfg_overlap;
                        m_tgt = int'(cfg_target);
                        m_state = M_READY;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                M_READY, M_DONE: begin
                    if (abort) m_state = M_IDLE;
                    else if (start) begin
                        m_cnt = 0;
                        hist.delete();
                        m_state = M_RUN;
                    end
                end
                M_RUN: begin
                    if (abort) m_state = M_DONE;
                    else if (x_valid) begin
                        hist.push_back(int'(x));
                        if (hist.size() > int'(PAT_W)) void'(hist.pop_front());
                        if (hist.size() >= m_len && tail(m_len) == (m_pat % (1 << m_len))) begin
                            m_match = 1'b1;
                            if (m_cnt < 255) m_cnt++;
                            if (!m_ovl) hist.delete();
                            if (m_tgt != 0 && m_cnt == m_tgt) m_state = M_DONE;
                        end
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (match === m_match) else begin
            errors++; $error("FAIL %s match got=%0b exp=%0b", tag, match, m_match);
        end
        checks++;
        assert (match_cnt === CNT_W'(m_cnt)) else begin
            errors++; $error("FAIL %s match_cnt got=%0d exp=%0d", tag, match_cnt, m_cnt);
        end
        checks++;
        assert (cfg_err === m_err) else begin
            errors++; $error("FAIL %s cfg_err got=%0b exp=%0b", tag, cfg_err, m_err);
        end
        checks++;
        assert (cfg_ready === (m_state == M_IDLE)) else begin
            errors++; $error("FAIL %s cfg_ready got=%0b exp=%0b", tag, cfg_ready, m_state == M_IDLE);
        end
        checks++;
        assert (busy === (m_state == M_RUN)) else begin
            errors++; $error("FAIL %s busy got=%0b exp=%0b", tag, busy, m_state == M_RUN);
        end
        checks++;
        assert (done === (m_state == M_DONE)) else begin
            errors++; $error("FAIL %s done got=%0b exp=%0b", tag, done, m_state == M_DONE);
        end
    endtask

    // Explicit spot check against a value fixed by the scenario.
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked #1 later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0; rst = 1'b0;
    endtask

    task automatic do_cfg(input int pat, input int len, input bit ovl, input int tgt, input string tag);
        cfg_valid = 1'b1;
        cfg_pattern = PAT_W'(pat);
        cfg_len = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_target = CNT_W'(tgt);
        tick(tag);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1; tick(tag); start = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        abort = 1'b1; tick(tag); abort = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            x_valid = 1'b1; x = bits[i];
            tick(tag);
        end
        x_valid = 1'b0;
        tick(tag);
    endtask

    initial begin
        quiet();
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        to_limit = '0;
`endif
        m_state = M_IDLE; m_pat = 0; m_len = 0; m_tgt = 0; m_cnt = 0; m_ovl = 1'b0;

        // Reset state
        rst = 1'b1;
        tick("reset");
        tick("reset");
        rst = 1'b0;
        tick("post_reset");
        chk("reset_ready", int'(cfg_ready), 1);

        // Non-overlapping 1010 over 101010
        do_cfg(8'b1010, 4, 1'b0, 0, "nonovl_cfg");
        do_start("nonovl_start");
        send_bits(16'b101010, 6, "nonovl");
        chk("nonovl_cnt", int'(match_cnt), 1);
        do_abort("nonovl_abort");
        do_abort("nonovl_idle");

        // Overlapping 1010 over 101010
        do_cfg(8'b1010, 4, 1'b1, 0, "ovl_cfg");
        do_start("ovl_start");
        send_bits(16'b101010, 6, "ovl");
        chk("ovl_cnt", int'(match_cnt), 2);
        do_abort("ovl_abort");
        do_abort("ovl_idle");

        // Target termination at two matches
        do_cfg(8'b1010, 4, 1'b1, 2, "tgt_cfg");
        do_start("tgt_start");
        send_bits(16'b1010101010, 10, "tgt");
        chk("tgt_done", int'(done), 1);
        chk("tgt_busy", int'(busy), 0);
        chk("tgt_cnt", int'(match_cnt), 2);
        do_abort("tgt_idle");

        // Illegal lengths
        do_cfg(8'h55, 0, 1'b0, 0, "illegal_len0");
        chk("len0_err", int'(cfg_err), 1);
        tick("illegal_gap");
        do_cfg(8'h55, 9, 1'b0, 0, "illegal_len9");
        chk("len9_err", int'(cfg_err), 1);
        chk("len9_ready", int'(cfg_ready), 1);

        // Abort on a completing bit, then rerun
        do_cfg(8'b1010, 4, 1'b0, 0, "abort_cfg");
        do_start("abort_start");
        send_bits(16'b1010, 4, "abort_pre");
        send_bits(16'b101, 3, "abort_mid");
        x_valid = 1'b1; x = 1'b0; abort = 1'b1;
        tick("abort_hit");
        quiet();
        chk("abort_nomatch", int'(match), 0);
        chk("abort_cnt", int'(match_cnt), 1);
        chk("abort_done", int'(done), 1);
        do_start("rerun_start");
        chk("rerun_cnt", int'(match_cnt), 0);
        chk("rerun_busy", int'(busy), 1);
        do_abort("rerun_done");
        do_abort("rerun_idle");

        // Reset mid-run, reconfigure, no stale window
        do_cfg(8'b1010, 4, 1'b0, 0, "rst_cfg");
        do_start("rst_start");
        send_bits(16'b101, 3, "rst_bits");
        rst = 1'b1;
        tick("rst_mid");
        rst = 1'b0;
        chk("rst_ready", int'(cfg_ready), 1);
        do_cfg(8'b1010, 4, 1'b0, 0, "rst_recfg");
        do_start("rst_restart");
        send_bits(16'b0, 1, "rst_bit0");
        chk("rst_nomatch_cnt", int'(match_cnt), 0);
        do_abort("rst_done");
        do_abort("rst_idle");

        // Counter saturation with a one-bit pattern
        do_cfg(8'b1, 1, 1'b1, 0, "sat_cfg");
        do_start("sat_start");
        x_valid = 1'b1; x = 1'b1;
        for (int i = 0; i < 260; i++) tick("sat");
        quiet();
        tick("sat_end");
        chk("sat_cnt", int'(match_cnt), 255);
        do_abort("sat_done");
        do_abort("sat_idle");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 399) == 0);
            cfg_valid   = ($urandom_range(0, 5) == 0);
            cfg_len     = LEN_W'($urandom_range(0, 9));
            cfg_pattern = PAT_W'($urandom);
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 4));
            start       = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            x_valid     = ($urandom_range(0, 3) != 0);
            x           = 1'($urandom);
            tick("random");
        end
        quiet();
        tick("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
